// File: rtl/cpu_ctrl.sv
// Pipeline control / exception unit at the MEM register output: stalls, flushes, fetch redirect and control registers.
// Build option: define CPU_IRQ_SYNC_EN to pass each irq line through a 2-flop synchronizer.

module cpu_ctrl_irq_sync (
    input  logic cpu_clk,
    input  logic cpu_rst,
    input  logic irq_in,
    output logic irq_out
);
`ifdef CPU_IRQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], irq_in};
    end

    assign irq_out = sync_q[1];
`else
    logic unused_clk_rst;

    assign unused_clk_rst = cpu_clk ^ cpu_rst;
    assign irq_out        = irq_in;
`endif
endmodule

module cpu_ctrl #(
    parameter logic [29:0] EXP_VECTOR_RST = 30'h0,
    parameter int          NUM_IRQ        = 8
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [29:0]        mem_pc,
    input  logic               mem_en,
    input  logic               mem_br_flag,
    input  logic [1:0]         mem_ctrl_op,
    input  logic [4:0]         mem_dst_addr,
    input  logic [2:0]         mem_exp_code,
    input  logic [31:0]        mem_out,
    input  logic               if_busy,
    input  logic               ld_hazard,
    input  logic               mem_busy,
    input  logic [2:0]         creg_rd_addr,
    output logic [31:0]        creg_rd_data,
    output logic               if_stall,
    output logic               id_stall,
    output logic               ex_stall,
    output logic               mem_stall,
    output logic               if_flush,
    output logic               id_flush,
    output logic               ex_flush,
    output logic               mem_flush,
    output logic [29:0]        new_pc,
    output logic               int_detect,
    output logic               exe_mode
);
    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_WRCR = 2'd1,
        OP_EXRT = 2'd2,
        OP_RSVD = 2'd3
    } ctrl_op_e;

    localparam logic [2:0] CR_STATUS     = 3'd0;
    localparam logic [2:0] CR_PRE_STATUS = 3'd1;
    localparam logic [2:0] CR_EPC        = 3'd2;
    localparam logic [2:0] CR_EXP_VECTOR = 3'd3;
    localparam logic [2:0] CR_CAUSE      = 3'd4;
    localparam logic [2:0] CR_INT_MASK   = 3'd5;
    localparam logic [2:0] CR_IRQ        = 3'd6;

    // STATUS / PRE_STATUS bit layout: {exe_mode, int_en}
    logic [1:0]         status;
    logic [1:0]         pre_status;
    logic [29:0]        epc;
    logic [29:0]        exp_vector;
    logic [3:0]         cause;
    logic [NUM_IRQ-1:0] int_mask;
    logic [NUM_IRQ-1:0] irq_reg;
    logic [NUM_IRQ-1:0] irq_s;

    logic     slot_live;
    logic     ev_exc;
    logic     ev_exrt;
    logic     ev_wrcr;
    logic     unused_dst_hi;
    ctrl_op_e op;

    assign unused_dst_hi = ^mem_dst_addr[4:3];
    assign op            = ctrl_op_e'(mem_ctrl_op);

    // A stalled MEM slot must not fire: it will be presented again once the bus wait clears.
    assign slot_live = mem_en & ~mem_busy;
    assign ev_exc    = slot_live & (mem_exp_code != 3'd0);
    assign ev_exrt   = slot_live & ~ev_exc & (op == OP_EXRT);
    assign ev_wrcr   = slot_live & ~ev_exc & (op == OP_WRCR);

    assign if_stall  = if_busy | ld_hazard | mem_busy;
    assign id_stall  = ld_hazard | mem_busy;
    assign ex_stall  = mem_busy;
    assign mem_stall = mem_busy;

    assign if_flush  = ev_exc | ev_exrt;
    assign id_flush  = ev_exc | ev_exrt;
    assign ex_flush  = ev_exc | ev_exrt;
    assign mem_flush = ev_exc | ev_exrt;
    assign new_pc    = ev_exrt ? epc : exp_vector;

    assign exe_mode  = status[1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
            cpu_ctrl_irq_sync u_sync (
                .cpu_clk (cpu_clk),
                .cpu_rst (cpu_rst),
                .irq_in  (irq[gi]),
                .irq_out (irq_s[gi])
            );
        end
    endgenerate

    // Pending interrupts keep sampling through stalls so int_detect never goes stale.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            irq_reg    <= '0;
            int_detect <= 1'b0;
        end else begin
            irq_reg    <= irq_s;
            int_detect <= status[0] & (|(irq_reg & ~int_mask));
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            status     <= 2'b00;
            pre_status <= 2'b00;
            epc        <= 30'h0;
            exp_vector <= EXP_VECTOR_RST;
            cause      <= 4'h0;
            int_mask   <= '1;
        end else if (ev_exc) begin
            // A faulting delay-slot instruction restarts at its branch.
            epc        <= mem_br_flag ? (mem_pc - 30'd1) : mem_pc;
            cause      <= {mem_br_flag, mem_exp_code};
            pre_status <= status;
            status     <= 2'b00;
        end else if (ev_exrt) begin
            status     <= pre_status;
        end else if (ev_wrcr) begin
            case (mem_dst_addr[2:0])
                CR_STATUS:     status     <= mem_out[1:0];
                CR_PRE_STATUS: pre_status <= mem_out[1:0];
                CR_EPC:        epc        <= mem_out[31:2];
                CR_EXP_VECTOR: exp_vector <= mem_out[31:2];
                CR_CAUSE:      cause      <= mem_out[3:0];
                CR_INT_MASK:   int_mask   <= mem_out[NUM_IRQ-1:0];
                default:       ;
            endcase
        end
    end

    always_comb begin
        creg_rd_data = 32'h0;
        case (creg_rd_addr)
            CR_STATUS:     creg_rd_data = {30'h0, status};
            CR_PRE_STATUS: creg_rd_data = {30'h0, pre_status};
            CR_EPC:        creg_rd_data = {epc, 2'b00};
            CR_EXP_VECTOR: creg_rd_data = {exp_vector, 2'b00};
            CR_CAUSE:      creg_rd_data = {28'h0, cause};
            CR_INT_MASK:   creg_rd_data = 32'(int_mask);
            CR_IRQ:        creg_rd_data = 32'(irq_reg);
            default:       creg_rd_data = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed scenarios plus randomized traffic checked against a register-level reference model.

module tb_cpu_ctrl;
    localparam int NIRQ = 8;
`ifdef CPU_IRQ_SYNC_EN
    localparam int IRQ_LAT = 4;
`else
    localparam int IRQ_LAT = 2;
`endif

    logic            cpu_clk, cpu_rst;
    logic [NIRQ-1:0] irq;
    logic [29:0]     mem_pc;
    logic            mem_en, mem_br_flag;
    logic [1:0]      mem_ctrl_op;
    logic [4:0]      mem_dst_addr;
    logic [2:0]      mem_exp_code;
    logic [31:0]     mem_out;
    logic            if_busy, ld_hazard, mem_busy;
    logic [2:0]      creg_rd_addr;
    logic [31:0]     creg_rd_data;
    logic            if_stall, id_stall, ex_stall, mem_stall;
    logic            if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0]     new_pc;
    logic            int_detect, exe_mode;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [1:0]      m_status, m_pre;
    logic [29:0]     m_epc, m_ev;
    logic [3:0]      m_cause;
    logic [NIRQ-1:0] m_mask;
    logic [NIRQ-1:0] m_hist [0:2];   // irq input as seen 1, 2, 3 edges ago
    logic            m_intdet;

    cpu_ctrl #(.EXP_VECTOR_RST(30'h0), .NUM_IRQ(NIRQ)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .irq(irq),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
        .mem_exp_code(mem_exp_code), .mem_out(mem_out),
        .if_busy(if_busy), .ld_hazard(ld_hazard), .mem_busy(mem_busy),
        .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .new_pc(new_pc), .int_detect(int_detect), .exe_mode(exe_mode)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NIRQ-1:0] m_irqreg();
`ifdef CPU_IRQ_SYNC_EN
        return m_hist[2];
`else
        return m_hist[0];
`endif
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0:    return {30'h0, m_status};
            3'd1:    return {30'h0, m_pre};
            3'd2:    return {m_epc, 2'b00};
            3'd3:    return {m_ev, 2'b00};
            3'd4:    return {28'h0, m_cause};
            3'd5:    return {24'h0, m_mask};
            3'd6:    return {24'h0, m_irqreg()};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = 2'b00; m_pre = 2'b00; m_epc = 30'h0; m_ev = 30'h0;
        m_cause = 4'h0; m_mask = '1; m_intdet = 1'b0;
        for (int k = 0; k < 3; k++) m_hist[k] = '0;
    endtask

    task automatic model_edge();
        logic nxt_int;
        nxt_int = m_status[0] & (|(m_irqreg() & ~m_mask));
        if (!mem_busy && mem_en) begin
            if (mem_exp_code != 3'd0) begin
                m_epc    = mem_br_flag ? mem_pc - 30'd1 : mem_pc;
                m_cause  = {mem_br_flag, mem_exp_code};
                m_pre    = m_status;
                m_status = 2'b00;
            end else if (mem_ctrl_op == 2'd2) begin
                m_status = m_pre;
            end else if (mem_ctrl_op == 2'd1) begin
                case (mem_dst_addr[2:0])
                    3'd0: m_status = mem_out[1:0];
                    3'd1: m_pre    = mem_out[1:0];
                    3'd2: m_epc    = mem_out[31:2];
                    3'd3: m_ev     = mem_out[31:2];
                    3'd4: m_cause  = mem_out[3:0];
                    3'd5: m_mask   = mem_out[NIRQ-1:0];
                    default: ;
                endcase
            end
        end
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = irq;
        m_intdet  = nxt_int;
    endtask

    task automatic check_outs();
        logic fl, exrt;
        exrt = !mem_busy && mem_en && mem_exp_code == 3'd0 && mem_ctrl_op == 2'd2;
        fl   = exrt || (!mem_busy && mem_en && mem_exp_code != 3'd0);
        chk("stalls", {if_stall, id_stall, ex_stall, mem_stall},
            {if_busy | ld_hazard | mem_busy, ld_hazard | mem_busy, mem_busy, mem_busy});
        chk("flushes", {if_flush, id_flush, ex_flush, mem_flush}, {4{fl}});
        if (fl) chk("new_pc", new_pc, exrt ? m_epc : m_ev);
        chk("rd_data", creg_rd_data, m_rd(creg_rd_addr));
        chk("exe_mode", exe_mode, m_status[1]);
        chk("int_detect", int_detect, m_intdet);
    endtask

    task automatic step();
        @(negedge cpu_clk);
        check_outs();
        @(posedge cpu_clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        mem_en = 0; mem_br_flag = 0; mem_ctrl_op = 0; mem_dst_addr = 0;
        mem_exp_code = 0; mem_out = 0; mem_pc = 0;
        if_busy = 0; ld_hazard = 0; mem_busy = 0;
    endtask

    task automatic wrcr(input logic [2:0] a, input logic [31:0] d);
        idle();
        mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = {2'b00, a}; mem_out = d;
        step();
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        creg_rd_addr = a;
        #1;
        chk(tag, creg_rd_data, exp);
    endtask

    task automatic do_reset();
        cpu_rst = 1;
        #1;
        model_reset();
        check_outs();
        @(posedge cpu_clk);
        #1;
        cpu_rst = 0;
    endtask

    initial begin
        cpu_rst = 1; irq = '0; creg_rd_addr = 0;
        idle();
        model_reset();
        #12;
        rd_chk("rst_status", 3'd0, 32'h0);
        rd_chk("rst_int_mask", 3'd5, 32'h0000_00FF);
        rd_chk("rst_exp_vector", 3'd3, 32'h0);
        chk("rst_flushes", {if_flush, id_flush, ex_flush, mem_flush}, 4'h0);
        chk("rst_int_detect", int_detect, 1'b0);
        @(posedge cpu_clk);
        #1;
        cpu_rst = 0;

        // Misaligned-access exception, no delay slot
        idle();
        mem_en = 1; mem_exp_code = 3'd4; mem_pc = 30'h100;
        #1;
        chk("exc_flushes", {if_flush, id_flush, ex_flush, mem_flush}, 4'hF);
        chk("exc_new_pc", new_pc, 30'h0);
        step();
        idle();
        rd_chk("exc_epc", 3'd2, 32'h400);
        rd_chk("exc_cause", 3'd4, 32'h4);
        rd_chk("exc_status", 3'd0, 32'h0);

        // Delay-slot exception at pc 0 wraps EPC
        mem_en = 1; mem_exp_code = 3'd4; mem_pc = 30'h0; mem_br_flag = 1;
        step();
        idle();
        rd_chk("wrap_epc", 3'd2, 32'hFFFF_FFFC);
        rd_chk("wrap_cause", 3'd4, 32'hC);

        // STATUS=3, exception saves it, EXRT restores it
        wrcr(3'd0, 32'h3);
        idle();
        mem_en = 1; mem_exp_code = 3'd5; mem_pc = 30'h200;
        step();
        idle();
        mem_en = 1; mem_ctrl_op = 2'd2;
        #1;
        chk("exrt_flushes", {if_flush, id_flush, ex_flush, mem_flush}, 4'hF);
        chk("exrt_new_pc", new_pc, 30'h200);
        step();
        idle();
        rd_chk("exrt_status", 3'd0, 32'h3);
        rd_chk("exrt_pre", 3'd1, 32'h3);
        chk("exrt_exe_mode", exe_mode, 1'b1);

        // Exception held off by mem_busy
        mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h300; mem_busy = 1;
        creg_rd_addr = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("busy_flushes", {if_flush, id_flush, ex_flush, mem_flush}, 4'h0);
            chk("busy_epc", creg_rd_data, 32'h800);
            step();
        end
        mem_busy = 0;
        #1;
        chk("unbusy_flushes", {if_flush, id_flush, ex_flush, mem_flush}, 4'hF);
        step();
        idle();
        rd_chk("unbusy_epc", 3'd2, 32'hC00);
        ld_hazard = 1;
        #1;
        chk("ld_hazard_stalls", {if_stall, id_stall, ex_stall, mem_stall}, 4'b1100);
        idle();

        // Interrupt latency and masking
        wrcr(3'd0, 32'h1);
        wrcr(3'd5, 32'hFE);
        idle();
        step();
        irq = 8'h01;
        for (int i = 1; i <= IRQ_LAT; i++) begin
            step();
            chk("irq_latency", int_detect, i == IRQ_LAT);
        end
        irq = 8'h00;
        repeat (IRQ_LAT + 1) step();
        irq = 8'h02;
        for (int i = 0; i < IRQ_LAT + 2; i++) begin
            step();
            chk("irq_masked", int_detect, 1'b0);
        end
        irq = 8'h00;

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            if (it == 200) do_reset();
            mem_en       = ($urandom_range(3) != 0);
            mem_busy     = ($urandom_range(3) == 0);
            if_busy      = ($urandom_range(4) == 0);
            ld_hazard    = ($urandom_range(4) == 0);
            mem_exp_code = ($urandom_range(4) == 0) ? 3'($urandom_range(6, 1)) : 3'd0;
            mem_ctrl_op  = 2'($urandom);
            mem_dst_addr = 5'($urandom);
            mem_out      = $urandom;
            mem_pc       = ($urandom_range(7) == 0) ? 30'h0 : 30'($urandom);
            mem_br_flag  = 1'($urandom);
            if ($urandom_range(3) == 0) irq = 8'($urandom);
            creg_rd_addr = 3'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Pipeline control and exception unit at the output of the MEM pipeline register. It consumes the registered MEM-stage fields (pc, en, br_flag, ctrl_op, dst_addr, exp_code, out) and holds the control registers. It drives the per-stage stall and flush signals back into the pipeline registers, including mem_reg's own stall and flush inputs. It redirects fetch on exceptions and on exception return.

Parameters:
EXP_VECTOR_RST  30'h0  reset value of the exception vector register (word address)
NUM_IRQ         8      number of external interrupt lines (1..30)

Ports:
cpu_clk       input   1        CPU clock
cpu_rst       input   1        async reset, active-high
irq           input   NUM_IRQ  external interrupt requests, level-sensitive
mem_pc        input   30       MEM-stage PC (word address)
mem_en        input   1        MEM-stage slot valid
mem_br_flag   input   1        MEM instruction sits in a branch delay slot
mem_ctrl_op   input   2        0 NOP, 1 WRCR (write ctrl reg), 2 EXRT (exception return), 3 reserved (treated as NOP)
mem_dst_addr  input   5        control register index for WRCR (bits [2:0] used)
mem_exp_code  input   3        0 none, 1 INT, 2 UNDEF, 3 OVERFLOW, 4 MISS_ALIGN, 5 TRAP, 6 PRV
mem_out       input   32       WRCR write data
if_busy       input   1        fetch bus wait
ld_hazard     input   1        load-use hazard detected in ID
mem_busy      input   1        data bus wait
creg_rd_addr  input   3        ID-stage control register read index
creg_rd_data  output  32       combinational read data
if_stall, id_stall, ex_stall, mem_stall  output  1 each  stage hold
if_flush, id_flush, ex_flush, mem_flush  output  1 each  stage bubble
new_pc        output  30       fetch redirect target, valid while if_flush=1
int_detect    output  1        registered unmasked-interrupt-pending flag to ID
exe_mode      output  1        0 kernel, 1 user (STATUS[1])

Behaviour:
- Control register map. Reads are zero-extended to 32; unmapped indices read 0 and ignore writes.
  - 0 STATUS {exe_mode, int_en}.
  - 1 PRE_STATUS.
  - 2 EPC: read as {epc, 2'b00}; written from mem_out[31:2].
  - 3 EXP_VECTOR: same format as EPC.
  - 4 CAUSE {dly, exp_code[2:0]}.
  - 5 INT_MASK [NUM_IRQ-1:0]: 1 = masked.
  - 6 IRQ: pending, read-only.
- Reset values:
  - STATUS=0, PRE_STATUS=0, EPC=0, EXP_VECTOR=EXP_VECTOR_RST, CAUSE=0.
  - INT_MASK=all ones, IRQ=0, int_detect=0.
  - Combinational outputs follow from these register values.
- Stall, combinational:
  - if_stall = if_busy|ld_hazard|mem_busy.
  - id_stall = ld_hazard|mem_busy.
  - ex_stall = mem_busy.
  - mem_stall = mem_busy.
- Event evaluation occurs only when mem_busy=0. While mem_busy=1: all flushes are 0, no control register changes except IRQ/int_detect.
- Priority: exception > EXRT > WRCR. Every event requires mem_en=1.
- Exception (mem_exp_code!=0):
  - Same cycle: all four flushes=1; new_pc=EXP_VECTOR.
  - At the clock edge:
    - EPC <= mem_br_flag ? mem_pc-1 : mem_pc (mod 2^30, wraps 0 -> 3FFFFFFF).
    - CAUSE <= {mem_br_flag, mem_exp_code}.
    - PRE_STATUS <= STATUS.
    - STATUS <= 0 (kernel, interrupts off).
  - ctrl_op is ignored.
- EXRT (no exception, ctrl_op=2):
  - Same cycle: all four flushes=1; new_pc=EPC.
  - At the clock edge: STATUS <= PRE_STATUS.
- WRCR (no exception, ctrl_op=1): creg[dst_addr[2:0]] <= mem_out at the clock edge; no flush.
- With no event: flushes=0; new_pc=EXP_VECTOR (don't-care).
- Redirect latency: the target is fetched in the cycle after the flush.
- IRQ register:
  - Updates every cycle from the irq input path, independent of stall.
  - int_detect <= STATUS.int_en & |(IRQ & ~INT_MASK), registered. It uses the pre-edge register values.
  - A WRCR to STATUS or INT_MASK affects int_detect one cycle after the write edge.
- Same-cycle conflicts:
  - An exception in the same cycle as a WRCR: the exception wins.
  - If an exception and an EXRT update STATUS in the same cycle, the exception wins.
- Reset mid-operation: all registers return to reset values immediately; flushes and new_pc follow combinationally.

Optional Feature:
CPU_IRQ_SYNC_EN:
- Defined: each irq bit passes a 2-flop synchronizer (reset 0) before the IRQ register. Assert-to-int_detect latency is 4 cycles.
- Undefined: irq samples directly into the IRQ register. Latency is 2 cycles.
- CPU_IRQ_SYNC_EN changes only irq sampling; all other behaviour is identical.

Test Plan:
- Reset, then read all control regs -> STATUS=0, INT_MASK=32'h000000FF, EXP_VECTOR read=0, flushes=0, int_detect=0.
- mem_en=1, exp_code=4, pc=30'h100, br_flag=0, mem_busy=0 -> flushes all 1 and new_pc=EXP_VECTOR that cycle; next cycle EPC read=32'h400, CAUSE=4'h4, STATUS=0.
- Same with br_flag=1, pc=30'h0 -> EPC=30'h3FFFFFFF, CAUSE=4'hC.
- WRCR STATUS=3 then EXRT after an exception -> EXRT cycle flushes=1, new_pc=EPC; next cycle STATUS=PRE_STATUS=3, exe_mode=1.
- Exception held with mem_busy=1 for 3 cycles -> flushes 0, EPC unchanged; the event fires in the first cycle with mem_busy=0. ld_hazard=1 alone -> if/id_stall=1, ex/mem_stall=0.
- STATUS.int_en=1, INT_MASK=FE, irq[0] raised -> int_detect=1 after 2 cycles (4 with CPU_IRQ_SYNC_EN). irq[1] with mask bit 1 set -> int_detect stays 0.
